player_link_rx: RTL and testbench

- Receiving end of a board-to-board player-control link: a second board drives player-2 controls over three Pmod wires using an SPI-style stream (sclk, active-low chip select, serial data), the same signalling style the OLED path uses outbound.
- Block synchronises the wires into clk, deserialises 16-bit frames and validates sync and checksum.
- Presents movement/jump/attack controls in place of the sw[15:13] player-2 inputs, plus link-health status.

---
 rtl/player_link_rx.sv | 179 +++++++++++++++++
 tb/tb_player_link_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_link_rx.sv
// Player-2 control link receiver: SPI-style frame deserialiser with sync/checksum check.
// Define PLAYER_LINK_HOLD_EN to keep the last good controls when the link times out.
module player_link_rx #(
  parameter int unsigned FRAME_TIMEOUT = 100000,
  parameter int unsigned LINK_TIMEOUT  = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       link_sclk,
  input  logic       link_cs_n,
  input  logic       link_sdin,
  output logic       ctrl_valid,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic [1:0] attack,
  output logic       link_up,
  output logic [7:0] frame_err_count
);

  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int LT_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [FT_W-1:0] FT_MAX = FT_W'(FRAME_TIMEOUT);
  localparam logic [LT_W-1:0] LT_MAX = LT_W'(LINK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ABORT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sclk_q, cs_q;
  logic [1:0]      sdin_q;
  logic [15:0]     sr_q, sr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [FT_W-1:0] tmo_q, tmo_d;
  logic [LT_W-1:0] lnk_q, lnk_d;
  logic [7:0]      err_q, err_d;
  logic            valid_q, valid_d;
  logic            left_q, left_d;
  logic            right_q, right_d;
  logic            jump_q, jump_d;
  logic [1:0]      atk_q, atk_d;
  logic            up_q, up_d;

  logic sclk_rise, cs_fall, cs_rise, good;

  // cs_n synchroniser resets low so a frame already in flight at
  // reset release never produces a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      sdin_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], link_sclk};
      cs_q   <= {cs_q[1:0], link_cs_n};
      sdin_q <= {sdin_q[0], link_sdin};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];

  assign good = (cnt_q == 5'd16) &&
                (sr_q[15:12] == 4'hA) &&
                (sr_q[3:0] == (sr_q[11:8] ^ sr_q[7:4] ^ 4'h5));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    lnk_d   = lnk_q;
    err_d   = err_q;
    valid_d = 1'b0;
    left_d  = left_q;
    right_d = right_q;
    jump_d  = jump_q;
    atk_d   = atk_q;
    up_d    = up_q;

    if (lnk_q != LT_MAX) begin
      lnk_d = lnk_q + LT_W'(1);
    end else begin
      up_d = 1'b0;
`ifndef PLAYER_LINK_HOLD_EN
      left_d  = 1'b0;
      right_d = 1'b0;
      jump_d  = 1'b0;
      atk_d   = 2'b00;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          sr_d  = {sr_q[14:0], sdin_q[1]};
          cnt_d = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
        end
        if (cs_rise) begin
          state_d = CHECK;
        end else if (tmo_q == FT_MAX) begin
          state_d = ABORT;
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end else begin
          tmo_d = tmo_q + FT_W'(1);
        end
      end
      ABORT: begin
        if (cs_q[1]) state_d = IDLE;
      end
      CHECK: begin
        if (good) begin
          valid_d = 1'b1;
          left_d  = sr_q[11] & ~sr_q[10];
          right_d = sr_q[10] & ~sr_q[11];
          jump_d  = sr_q[9];
          atk_d   = sr_q[8:7];
          lnk_d   = '0;
          up_d    = 1'b1;
        end else begin
          err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lnk_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      jump_q  <= 1'b0;
      atk_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      lnk_q   <= lnk_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      left_q  <= left_d;
      right_q <= right_d;
      jump_q  <= jump_d;
      atk_q   <= atk_d;
      up_q    <= up_d;
    end
  end

  assign ctrl_valid      = valid_q;
  assign move_left       = left_q;
  assign move_right      = right_q;
  assign jump            = jump_q;
  assign attack          = atk_q;
  assign link_up         = up_q;
  assign frame_err_count = err_q;

endmodule

// File: tb/tb_player_link_rx.sv
// Bench for player_link_rx: frame-level reference model with a ctrl_valid scoreboard.
// Honours PLAYER_LINK_HOLD_EN for the link-timeout expectation.
module tb_player_link_rx;

  localparam int FT   = 200;
  localparam int LT   = 20000;
  localparam int HALF = 5;

  typedef struct packed {
    logic       l;
    logic       r;
    logic       j;
    logic [1:0] a;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       link_sclk = 1'b0;
  logic       link_cs_n = 1'b1;
  logic       link_sdin = 1'b0;
  logic       ctrl_valid;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic [1:0] attack;
  logic       link_up;
  logic [7:0] frame_err_count;

  int   n_chk = 0;
  int   n_fail = 0;
  ctl_t q[$];
  ctl_t m_ctl = '0;
  int   m_err = 0;
  int   m_up = 0;

  player_link_rx #(.FRAME_TIMEOUT(FT), .LINK_TIMEOUT(LT)) dut (
    .clk(clk),
    .reset(reset),
    .link_sclk(link_sclk),
    .link_cs_n(link_cs_n),
    .link_sdin(link_sdin),
    .ctrl_valid(ctrl_valid),
    .move_left(move_left),
    .move_right(move_right),
    .jump(jump),
    .attack(attack),
    .link_up(link_up),
    .frame_err_count(frame_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ctrl_valid pulse must match the oldest expected frame.
  initial begin
    ctl_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && ctrl_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_left", int'(move_left), int'(e.l));
          chk("sb_right", int'(move_right), int'(e.r));
          chk("sb_jump", int'(jump), int'(e.j));
          chk("sb_attack", int'(attack), int'(e.a));
          chk("sb_link_up", int'(link_up), 1);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input int pl);
    int ck;
    ck = ((pl >> 4) & 15) ^ (pl & 15) ^ 5;
    return 32'((10 << 12) | ((pl & 255) << 4) | ck);
  endfunction

  task automatic model(input logic [31:0] d, input int n);
    int   sy, pl, ck;
    ctl_t e;
    sy = int'((d >> 12) & 32'hF);
    pl = int'((d >> 4) & 32'hFF);
    ck = int'(d & 32'hF);
    if (n == 16 && sy == 10 && ck == (((pl >> 4) ^ (pl & 15) ^ 5))) begin
      e.l = ((pl >> 7) & 1) != 0;
      e.r = ((pl >> 6) & 1) != 0;
      if (e.l && e.r) begin
        e.l = 1'b0;
        e.r = 1'b0;
      end
      e.j = ((pl >> 5) & 1) != 0;
      e.a = 2'((pl >> 3) & 3);
      q.push_back(e);
      m_ctl = e;
      m_up = 1;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic send_bit(input logic b);
    link_sdin = b;
    repeat (HALF) @(negedge clk);
    link_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    link_sclk = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_err"}, int'(frame_err_count), m_err);
    chk({tag, "_up"}, int'(link_up), m_up);
    chk({tag, "_left"}, int'(move_left), int'(m_ctl.l));
    chk({tag, "_right"}, int'(move_right), int'(m_ctl.r));
    chk({tag, "_jump"}, int'(jump), int'(m_ctl.j));
    chk({tag, "_attack"}, int'(attack), int'(m_ctl.a));
    chk({tag, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  task automatic send(input string tag, input logic [31:0] d, input int n);
    model(d, n);
    @(negedge clk);
    link_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
    repeat (6) @(negedge clk);
    link_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    logic [31:0] d;
    int          kind, pl, n;

    #1;
    chk("rst_valid", int'(ctrl_valid), 0);
    chk("rst_left", int'(move_left), 0);
    chk("rst_up", int'(link_up), 0);
    chk("rst_err", int'(frame_err_count), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    send("good_a984", 32'hA984, 16);
    send("badchk_a985", 32'hA985, 16);
    send("short15", 32'h0A98, 15);
    send("long17", 32'h15309, 17);
    send("good_a207", 32'hA207, 16);
    send("lr_ac09", 32'hAC09, 16);

    @(negedge clk);
    link_cs_n = 1'b0;
    repeat (FT + 10) @(negedge clk);
    if (m_err < 255) m_err++;
    chk("tmo_err", int'(frame_err_count), m_err);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    link_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_state("tmo_after");

    for (int it = 0; it < 25; it++) begin
      kind = int'($urandom_range(0, 4));
      pl = int'($urandom_range(0, 255));
      d = mk(pl);
      n = 16;
      case (kind)
        2: d = d ^ 32'($urandom_range(1, 15));
        3: d = d ^ 32'($urandom_range(1, 15) << 12);
        4: begin
          n = int'($urandom_range(0, 1)) != 0 ?
              int'($urandom_range(17, 19)) : int'($urandom_range(12, 15));
          d = $urandom;
        end
        default: ;
      endcase
      send("rand", d, n);
    end

    send("pre_rst", 32'hA984, 16);
    @(negedge clk);
    link_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 15; i >= 8; i--) send_bit(d[i]);
    reset = 1'b1;
    #1;
    chk("mid_rst_left", int'(move_left), 0);
    chk("mid_rst_attack", int'(attack), 0);
    chk("mid_rst_up", int'(link_up), 0);
    chk("mid_rst_err", int'(frame_err_count), 0);
    m_ctl = '0;
    m_err = 0;
    m_up = 0;
    q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    link_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_state("partial");

    send("post_rst", 32'hA984, 16);
    repeat (LT + 20) @(negedge clk);
    m_up = 0;
`ifndef PLAYER_LINK_HOLD_EN
    m_ctl = '0;
`endif
    check_state("link_tmo");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
